ppu_vram_arbiter: RTL and testbench

- Owns the single PPU VRAM bus and shares it between three requesters: background fetcher, sprite fetcher and the CPU PPUDATA ($2007) port.
- During the rendering window, ownership is fixed by dot position (x_idx/scanline). Outside it, CPU accesses are sequenced by a small FSM with the $2007 read buffer.
- Sits between the fetch units/register file and the VRAM/CHR memory. The memory is synchronous: read data is valid the cycle after the address is presented.

---
 rtl/ppu_vram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ppu_vram_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_arbiter.sv
// Shares the PPU VRAM bus between the BG fetcher, the sprite fetcher and the CPU $2007 port.
// Render-window ownership is by dot position; CPU accesses are sequenced by a small FSM with a read buffer.
module ppu_vram_arbiter #(
    parameter int          LAST_RENDER_LINE = 240,
    parameter int          SPR_FIRST_DOT    = 256,
    parameter int          SPR_LAST_DOT     = 319,
    parameter logic [13:0] PAL_BASE         = 14'h3F00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  x_idx,
    input  logic [9:0]  scanline,
    input  logic        rendering_en,
    input  logic [15:0] bg_addr,
    output logic [7:0]  bg_data,
    input  logic [15:0] spr_addr,
    output logic [7:0]  spr_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic [13:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [1:0]  owner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PEND,
        S_ACCESS,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [1:0] OWN_CPU = 2'd0;
    localparam logic [1:0] OWN_BG  = 2'd1;
    localparam logic [1:0] OWN_SPR = 2'd2;

    localparam logic [9:0] LAST_LINE = 10'(LAST_RENDER_LINE);
    localparam logic [9:0] SPR_FIRST = 10'(SPR_FIRST_DOT);
    localparam logic [9:0] SPR_LAST  = 10'(SPR_LAST_DOT);

    state_t      state_q, state_d;
    logic [13:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  rbuf_q, rbuf_d;

    logic render_win;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{bg_addr[15:14], spr_addr[15:14]};

    assign render_win = rendering_en && (scanline <= LAST_LINE);

    always_comb begin
        owner = OWN_CPU;
        if (render_win) begin
            if (x_idx >= SPR_FIRST && x_idx <= SPR_LAST) begin
                owner = OWN_SPR;
            end else begin
                owner = OWN_BG;
            end
        end
    end

    always_comb begin
        mem_addr = 14'h0;
        case (owner)
            OWN_BG:  mem_addr = bg_addr[13:0];
            OWN_SPR: mem_addr = spr_addr[13:0];
            default: begin
                if (state_q == S_ACCESS || state_q == S_CAPTURE) begin
                    mem_addr = addr_q;
                end
            end
        endcase
    end

    // Gating by owner keeps a write that straddles the window opening off the bus.
    assign mem_we    = (state_q == S_ACCESS) && we_q && (owner == OWN_CPU);
    assign mem_wdata = wdata_q;
    assign bg_data   = mem_rdata;
    assign spr_data  = mem_rdata;
    assign cpu_ack   = ack_q;
    assign cpu_rdata = rdata_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = render_win ? S_PEND : S_ACCESS;
                end
            end
            S_PEND: begin
                if (!render_win) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = render_win ? S_PEND : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (render_win) begin
                    state_d = S_PEND;
                end else begin
                    if (!we_q) begin
                        if (addr_q < PAL_BASE) begin
                            rdata_d = rbuf_q;
                            rbuf_d  = mem_rdata;
                        end else begin
                            rdata_d = mem_rdata;
                        end
                    end
                    ack_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Held request must drop before a new transaction can start.
                if (!cpu_req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= 14'h0;
            we_q    <= 1'b0;
            wdata_q <= 8'h0;
            ack_q   <= 1'b0;
            rdata_q <= 8'h0;
            rbuf_q  <= 8'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            rbuf_q  <= rbuf_d;
        end
    end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed bench for ppu_vram_arbiter with a synchronous 16K x 8 VRAM model.
module tb_ppu_vram_arbiter;

    logic        clk;
    logic        reset_n;
    logic [9:0]  x_idx;
    logic [9:0]  scanline;
    logic        rendering_en;
    logic [15:0] bg_addr;
    logic [7:0]  bg_data;
    logic [15:0] spr_addr;
    logic [7:0]  spr_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [1:0]  owner;

    logic [7:0] mem [0:16383];

    int total;
    int bad;

    ppu_vram_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .x_idx        (x_idx),
        .scanline     (scanline),
        .rendering_en (rendering_en),
        .bg_addr      (bg_addr),
        .bg_data      (bg_data),
        .spr_addr     (spr_addr),
        .spr_data     (spr_data),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ack      (cpu_ack),
        .cpu_rdata    (cpu_rdata),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .owner        (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a CPU read and waits (bounded) for the ack; drops the request and advances one cycle.
    task automatic do_read(input logic [13:0] a, output logic ok, output logic [7:0] d,
                           output int cycles, output logic ack_after);
        cpu_addr = a;
        cpu_we   = 1'b0;
        cpu_req  = 1'b1;
        ok       = 1'b0;
        cycles   = 0;
        d        = 8'h00;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            cycles++;
            if (cpu_ack === 1'b1) begin
                ok = 1'b1;
                d  = cpu_rdata;
            end
        end
        cpu_req = 1'b0;
        tick();
        ack_after = cpu_ack;
    endtask

    task automatic test_reset();
        total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", cpu_ack); end
        total++; if (cpu_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", cpu_rdata); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", mem_we); end
        total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner: got %0d want 0", owner); end
        total++; if (mem_addr !== 14'h0) begin bad++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
    endtask

    task automatic test_read_buffer();
        logic ok; logic [7:0] d; int cyc; logic aa;
        do_read(14'h2005, ok, d, cyc, aa);
        total++; if (!ok) begin bad++; $display("FAIL rb1_ack: no ack within budget"); end
        total++; if (cyc != 3) begin bad++; $display("FAIL rb1_latency: got %0d want 3", cyc); end
        total++; if (d !== 8'h00) begin bad++; $display("FAIL rb1_data: got %h want 00", d); end
        total++; if (aa !== 1'b0) begin bad++; $display("FAIL rb1_ack_pulse: got %b want 0", aa); end
        do_read(14'h2006, ok, d, cyc, aa);
        total++; if (!ok || d !== 8'hAB) begin bad++; $display("FAIL rb2_data: ok %b got %h want AB", ok, d); end
        do_read(14'h2000, ok, d, cyc, aa);
        total++; if (!ok || d !== 8'hCD) begin bad++; $display("FAIL rb3_data: ok %b got %h want CD", ok, d); end
    endtask

    task automatic test_palette();
        logic ok; logic [7:0] d; int cyc; logic aa;
        do_read(14'h2010, ok, d, cyc, aa);
        total++; if (!ok || d !== 8'h99) begin bad++; $display("FAIL pal_prime: ok %b got %h want 99", ok, d); end
        do_read(14'h3F01, ok, d, cyc, aa);
        total++; if (!ok || d !== 8'h21) begin bad++; $display("FAIL pal_direct: ok %b got %h want 21", ok, d); end
        total++; if (cyc != 3) begin bad++; $display("FAIL pal_latency: got %0d want 3", cyc); end
        do_read(14'h2000, ok, d, cyc, aa);
        total++; if (!ok || d !== 8'h55) begin bad++; $display("FAIL pal_buf_kept: ok %b got %h want 55", ok, d); end
    endtask

    task automatic test_write_deferred();
        int we_seen; int ack_seen;
        we_seen = 0; ack_seen = 0;
        rendering_en = 1'b1; scanline = 10'd100; x_idx = 10'd0;
        cpu_we = 1'b1; cpu_addr = 14'h2400; cpu_wdata = 8'h77; cpu_req = 1'b1;
        tick();
        cpu_addr = 14'h1111; cpu_wdata = 8'hEE;
        for (int i = 0; i < 20; i++) begin
            if (mem_we === 1'b1) we_seen++;
            if (cpu_ack === 1'b1) ack_seen++;
            tick();
        end
        scanline = 10'd240;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_we === 1'b1) we_seen++;
            if (cpu_ack === 1'b1) ack_seen++;
        end
        total++; if (we_seen != 0) begin bad++; $display("FAIL wr_no_we_render: got %0d want 0", we_seen); end
        total++; if (ack_seen != 0) begin bad++; $display("FAIL wr_no_ack_render: got %0d want 0", ack_seen); end
        scanline = 10'd241; x_idx = 10'd0;
        tick();
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL wr_we_pulse: got %b want 1", mem_we); end
        total++; if (mem_addr !== 14'h2400) begin bad++; $display("FAIL wr_addr: got %h want 2400", mem_addr); end
        total++; if (mem_wdata !== 8'h77) begin bad++; $display("FAIL wr_wdata: got %h want 77", mem_wdata); end
        we_seen = 0;
        tick();
        if (mem_we === 1'b1) we_seen++;
        total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL wr_ack_early: got %b want 0", cpu_ack); end
        tick();
        if (mem_we === 1'b1) we_seen++;
        total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL wr_ack: got %b want 1", cpu_ack); end
        total++; if (we_seen != 0) begin bad++; $display("FAIL wr_single_pulse: extra %0d pulses", we_seen); end
        total++; if (mem[14'h2400] !== 8'h77) begin bad++; $display("FAIL wr_mem: got %h want 77", mem[14'h2400]); end
        total++; if (cpu_rdata !== 8'h55) begin bad++; $display("FAIL wr_rdata_kept: got %h want 55", cpu_rdata); end
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        rendering_en = 1'b0;
    endtask

    task automatic test_ownership();
        int          xs [6] = '{0, 255, 256, 319, 320, 340};
        logic [1:0]  eo [6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1};
        logic [13:0] ea [6] = '{14'h0123, 14'h0123, 14'h1456, 14'h1456, 14'h0123, 14'h0123};
        rendering_en = 1'b1; scanline = 10'd50;
        bg_addr = 16'hC123; spr_addr = 16'h5456;
        for (int i = 0; i < 6; i++) begin
            x_idx = 10'(xs[i]);
            #1;
            total++;
            if (owner !== eo[i] || mem_addr !== ea[i]) begin
                bad++;
                $display("FAIL own_x%0d: owner %0d addr %h want owner %0d addr %h", xs[i], owner, mem_addr, eo[i], ea[i]);
            end
        end
        total++; if (bg_data !== mem_rdata || spr_data !== mem_rdata) begin
            bad++; $display("FAIL own_broadcast: bg %h spr %h want %h", bg_data, spr_data, mem_rdata); end
        scanline = 10'd241; x_idx = 10'd100; #1;
        total++; if (owner !== 2'd0 || mem_addr !== 14'h0) begin
            bad++; $display("FAIL own_line241: owner %0d addr %h want 0 0000", owner, mem_addr); end
        scanline = 10'd50; x_idx = 10'd300; rendering_en = 1'b0; #1;
        total++; if (owner !== 2'd0) begin bad++; $display("FAIL own_en_off: got %0d want 0", owner); end
        tick();
    endtask

    task automatic test_abort_replay();
        int ack_seen; logic ok; logic [7:0] d; int cyc; logic aa;
        ack_seen = 0; ok = 1'b0; d = 8'h00;
        bg_addr = 16'h0123;
        rendering_en = 1'b1; scanline = 10'd261; x_idx = 10'd339;
        cpu_we = 1'b0; cpu_addr = 14'h2006; cpu_req = 1'b1;
        tick();
        total++; if (owner !== 2'd0 || mem_addr !== 14'h2006) begin
            bad++; $display("FAIL ab_access: owner %0d addr %h want 0 2006", owner, mem_addr); end
        scanline = 10'd0; x_idx = 10'd0; #1;
        total++; if (owner !== 2'd1 || mem_we !== 1'b0) begin
            bad++; $display("FAIL ab_window_open: owner %0d we %b want 1 0", owner, mem_we); end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cpu_ack === 1'b1) ack_seen++;
        end
        scanline = 10'd240;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cpu_ack === 1'b1) ack_seen++;
        end
        total++; if (ack_seen != 0) begin bad++; $display("FAIL ab_no_ack: got %0d want 0", ack_seen); end
        total++; if (cpu_rdata !== 8'h55) begin bad++; $display("FAIL ab_no_capture: got %h want 55", cpu_rdata); end
        scanline = 10'd241;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            if (cpu_ack === 1'b1) begin ok = 1'b1; d = cpu_rdata; end
        end
        total++; if (!ok || d !== 8'h99) begin bad++; $display("FAIL ab_replay: ok %b got %h want 99", ok, d); end
        cpu_req = 1'b0;
        tick();
        rendering_en = 1'b0;
        do_read(14'h2000, ok, d, cyc, aa);
        total++; if (!ok || d !== 8'hCD) begin bad++; $display("FAIL ab_buf_after: ok %b got %h want CD", ok, d); end
    endtask

    task automatic test_async_reset();
        logic ok; logic [7:0] d; int cyc; logic aa;
        ok = 1'b0; d = 8'h00; cyc = 0;
        rendering_en = 1'b0; cpu_we = 1'b0; cpu_addr = 14'h2000; cpu_req = 1'b1;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        total++; if (cpu_ack !== 1'b0 || cpu_rdata !== 8'h00 || mem_we !== 1'b0 || mem_addr !== 14'h0) begin
            bad++; $display("FAIL rst_async: ack %b rdata %h we %b addr %h want 0 00 0 0000", cpu_ack, cpu_rdata, mem_we, mem_addr); end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            cyc++;
            if (cpu_ack === 1'b1) begin ok = 1'b1; d = cpu_rdata; end
        end
        total++; if (!ok || cyc != 3) begin bad++; $display("FAIL rst_held_req: ok %b cycles %0d want 1 3", ok, cyc); end
        total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_buf_cleared: got %h want 00", d); end
        cpu_req = 1'b0;
        tick();
        do_read(14'h2005, ok, d, cyc, aa);
        total++; if (!ok || d !== 8'h99) begin bad++; $display("FAIL rst_buf_reload: ok %b got %h want 99", ok, d); end
    endtask

    initial begin
        total = 0; bad = 0;
        for (int i = 0; i < 16384; i++) mem[i] <= 8'h00;
        mem[14'h2005] <= 8'hAB;
        mem[14'h2006] <= 8'hCD;
        mem[14'h2000] <= 8'h99;
        mem[14'h2010] <= 8'h55;
        mem[14'h3F01] <= 8'h21;
        reset_n = 1'b0; x_idx = 10'd0; scanline = 10'd0; rendering_en = 1'b0;
        bg_addr = 16'h0; spr_addr = 16'h0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 14'h0; cpu_wdata = 8'h0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        test_reset();
        test_read_buffer();
        test_palette();
        test_write_deferred();
        test_ownership();
        test_abort_replay();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
